rv32_load_store_unit: RTL and testbench

- Multicycle load/store unit between the multicycle core's memory stage and a handshaked data bus.
- Adds the sub-word accesses the core lacks: lb, lh, lbu, lhu, sb, sh, plus lw/sw.
- Generates byte enables, shifts store data, and aligns and sign- or zero-extends load data.
- Enforces a bus timeout and, optionally, splits misaligned accesses into two word beats.

---
 rtl/rv32_load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_rv32_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_load_store_unit.sv
// RV32I load/store unit: sub-word lanes, sign/zero extension and a bus-beat timeout.
// Optional LSU_MISALIGNED_SPLIT_EN runs misaligned accesses as two word beats instead of erroring.
module rv32_load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_wr_ena_o,
  output logic [3:0]        bus_byte_ena_o,
  output logic [31:0]       bus_wr_data_o,
  input  logic [31:0]       bus_rd_data_i,
  input  logic              bus_ack_i
);

  // state   | meaning
  // S_IDLE  | ready for a request
  // S_BEAT0 | bus beat at the word-aligned base address
  // S_BEAT1 | second beat at base+4 (split misaligned access only)
  // S_RESP  | one-cycle response pulse
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [31:0]       rd0_q, rd0_d;
  logic [31:0]       rd1_q, rd1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_legal, req_misaligned;
  logic [1:0]        ofs;
  logic [4:0]        sh_amt;
  logic [5:0]        sh_inv;
  logic [3:0]        size_mask;
  logic [7:0]        be_wide;
  logic [ADDR_W-1:0] base;
  logic              in_beat1;
  logic [31:0]       rd_merged, rd_ext;

  always_comb begin
    if (req_we_i)
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    else
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_misaligned = ((req_funct3_i[1:0] == 2'b01) && (req_addr_i[1:0] == 2'b11)) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  // Lane geometry from the latched request; beat 1 holds whatever overflowed past lane 3.
  assign ofs      = addr_q[1:0];
  assign sh_amt   = {ofs, 3'b000};
  assign sh_inv   = 6'd32 - {1'b0, sh_amt};
  assign base     = {addr_q[ADDR_W-1:2], 2'b00};
  assign in_beat1 = (state_q == S_BEAT1);

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign be_wide   = {4'b0000, size_mask} << ofs;
  assign rd_merged = (rd0_q >> sh_amt) | ((ofs == 2'b00) ? 32'h0 : (rd1_q << sh_inv));

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   rd_ext = {{24{~funct3_q[2] & rd_merged[7]}}, rd_merged[7:0]};
      2'b01:   rd_ext = {{16{~funct3_q[2] & rd_merged[15]}}, rd_merged[15:0]};
      default: rd_ext = rd_merged;
    endcase
  end

  assign req_ready_o    = ena_i && (state_q == S_IDLE);
  assign bus_req_o      = (state_q == S_BEAT0) || in_beat1;
  assign bus_addr_o     = in_beat1 ? (base + ADDR_W'(4)) : base;
  assign bus_wr_ena_o   = bus_req_o && we_q;
  assign bus_byte_ena_o = !bus_req_o ? 4'b0000 : (in_beat1 ? be_wide[7:4] : be_wide[3:0]);
  assign bus_wr_data_o  = in_beat1 ? ((ofs == 2'b00) ? 32'h0 : (wdata_q >> sh_inv))
                                   : (wdata_q << sh_amt);
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_error_o    = rsp_valid_o && err_q;
  assign rsp_rdata_o    = (rsp_valid_o && !err_q && !we_q) ? rd_ext : 32'h0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    split_d  = split_q;
    err_d    = err_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    cnt_d    = cnt_q;
    if (ena_i) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_d   = req_addr_i;
            funct3_d = req_funct3_i;
            we_d     = req_we_i;
            wdata_d  = req_wdata_i;
            err_d    = !req_legal || (req_misaligned && !SPLIT_EN);
            split_d  = req_misaligned && SPLIT_EN;
            rd0_d    = 32'h0;
            rd1_d    = 32'h0;
            cnt_d    = '0;
            state_d  = (!req_legal || (req_misaligned && !SPLIT_EN)) ? S_RESP : S_BEAT0;
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (bus_ack_i) begin
            if (!we_q) begin
              if (in_beat1) rd1_d = bus_rd_data_i;
              else          rd0_d = bus_rd_data_i;
            end
            cnt_d   = '0;
            state_d = (!in_beat1 && split_q) ? S_BEAT1 : S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // An ack on the final allowed cycle is taken by the branch above, so it wins.
            if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      rd0_q    <= 32'h0;
      rd1_q    <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      split_q  <= split_d;
      err_q    <= err_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Directed bench for rv32_load_store_unit with a small bus responder (programmable ack delay).
module tb_rv32_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_wr_ena, bus_ack;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [3:0]  bus_byte_ena;

  logic [31:0] mem [4];
  logic        ack_allow = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_lat, r_beats, r_req_cycles;
  logic        r_got, r_err;
  logic [31:0] r_rdata;
  logic [3:0]  r_be [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd [2];
  logic        r_wr [2];

  rv32_load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_wr_ena_o(bus_wr_ena),
    .bus_byte_ena_o(bus_byte_ena), .bus_wr_data_o(bus_wr_data),
    .bus_rd_data_i(bus_rd_data), .bus_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  assign bus_ack     = bus_req && ack_allow && (wait_cnt >= ack_delay);
  assign bus_rd_data = mem[bus_addr[3:2]];

  always @(posedge clk) begin
    if (!rst || !bus_req || (bus_ack && ena)) wait_cnt <= 0;
    else if (ena) wait_cnt <= wait_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle, then follows it to the response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick;
    req_valid = 1'b0;
    r_lat = 1; r_beats = 0; r_req_cycles = 0; r_got = 1'b0; r_err = 1'b0; r_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      r_be[k] = 4'h0; r_addr[k] = 32'h0; r_wd[k] = 32'h0; r_wr[k] = 1'b0;
    end
    for (int i = 0; i < 100 && !r_got; i++) begin
      if (rsp_valid) begin
        r_got = 1'b1; r_rdata = rsp_rdata; r_err = rsp_error;
      end else begin
        if (bus_req) begin
          r_req_cycles++;
          if (bus_ack && r_beats < 2) begin
            r_be[r_beats] = bus_byte_ena; r_addr[r_beats] = bus_addr;
            r_wd[r_beats] = bus_wr_data;  r_wr[r_beats] = bus_wr_ena;
            r_beats++;
          end
        end
        tick;
        r_lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ena = 1'b1;
    tick; tick;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
    rst = 1'b1;
    tick;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_ext;
    mem[0] = 32'h80FF7F01; ack_allow = 1'b1; ack_delay = 0;
    do_req(1'b0, 3'b100, 32'h1003, 32'h0);
    n_checks++; if (r_got !== 1'b1) begin n_fail++; $display("FAIL lbu_response: got %b expected 1", r_got); end
    n_checks++; if (r_be[0] !== 4'b1000) begin n_fail++; $display("FAIL lbu_byte_ena: got %b expected 1000", r_be[0]); end
    n_checks++; if (r_addr[0] !== 32'h1000) begin n_fail++; $display("FAIL lbu_bus_addr: got %h expected 00001000", r_addr[0]); end
    n_checks++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", r_rdata); end
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL lbu_latency: got %0d expected 2", r_lat); end
    tick;
    do_req(1'b0, 3'b000, 32'h1003, 32'h0);
    n_checks++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", r_rdata); end
    tick;
    do_req(1'b0, 3'b101, 32'h1002, 32'h0);
    n_checks++; if (r_be[0] !== 4'b1100) begin n_fail++; $display("FAIL lhu_byte_ena: got %b expected 1100", r_be[0]); end
    n_checks++; if (r_rdata !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 000080ff", r_rdata); end
    tick;
    do_req(1'b0, 3'b001, 32'h1002, 32'h0);
    n_checks++; if (r_rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffff80ff", r_rdata); end
    tick;
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    n_checks++; if (r_rdata !== 32'h80FF7F01) begin n_fail++; $display("FAIL lw_rdata: got %h expected 80ff7f01", r_rdata); end
    n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL lw_error: got %b expected 0", r_err); end
    tick;
  endtask

  task automatic test_store;
    do_req(1'b1, 3'b001, 32'h0102, 32'h1234BEEF);
    n_checks++; if (r_wr[0] !== 1'b1) begin n_fail++; $display("FAIL sh_wr_ena: got %b expected 1", r_wr[0]); end
    n_checks++; if (r_be[0] !== 4'b1100) begin n_fail++; $display("FAIL sh_byte_ena: got %b expected 1100", r_be[0]); end
    n_checks++; if (r_wd[0] !== 32'hBEEF0000) begin n_fail++; $display("FAIL sh_wr_data: got %h expected beef0000", r_wd[0]); end
    n_checks++; if (r_addr[0] !== 32'h0100) begin n_fail++; $display("FAIL sh_bus_addr: got %h expected 00000100", r_addr[0]); end
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL sh_latency: got %0d expected 2", r_lat); end
    n_checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL sh_response: got err %b data %h expected err 0 data 0", r_err, r_rdata); end
    tick;
    do_req(1'b1, 3'b000, 32'h1001, 32'h000000A5);
    n_checks++; if (r_be[0] !== 4'b0010) begin n_fail++; $display("FAIL sb_byte_ena: got %b expected 0010", r_be[0]); end
    n_checks++; if (r_wd[0] !== 32'h0000A500) begin n_fail++; $display("FAIL sb_wr_data: got %h expected 0000a500", r_wd[0]); end
    tick;
    do_req(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF);
    n_checks++; if (r_be[0] !== 4'b1111 || r_addr[0] !== 32'h1004) begin n_fail++; $display("FAIL sw_lanes: got be %b addr %h expected be 1111 addr 00001004", r_be[0], r_addr[0]); end
    n_checks++; if (r_wd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wr_data: got %h expected deadbeef", r_wd[0]); end
    tick;
  endtask

  task automatic test_misaligned;
    mem[0] = 32'h44332211; mem[1] = 32'h88776655;
    do_req(1'b0, 3'b010, 32'h1001, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    n_checks++; if (r_beats !== 2) begin n_fail++; $display("FAIL split_lw_beats: got %0d expected 2", r_beats); end
    n_checks++; if (r_be[0] !== 4'b1110 || r_be[1] !== 4'b0001) begin n_fail++; $display("FAIL split_lw_byte_ena: got %b/%b expected 1110/0001", r_be[0], r_be[1]); end
    n_checks++; if (r_addr[0] !== 32'h1000 || r_addr[1] !== 32'h1004) begin n_fail++; $display("FAIL split_lw_addr: got %h/%h expected 00001000/00001004", r_addr[0], r_addr[1]); end
    n_checks++; if (r_rdata !== 32'h55443322 || r_err !== 1'b0) begin n_fail++; $display("FAIL split_lw_rdata: got %h err %b expected 55443322 err 0", r_rdata, r_err); end
    n_checks++; if (r_lat !== 3) begin n_fail++; $display("FAIL split_lw_latency: got %0d expected 3", r_lat); end
    tick;
    do_req(1'b1, 3'b001, 32'h1003, 32'h0000BEEF);
    n_checks++; if (r_be[0] !== 4'b1000 || r_be[1] !== 4'b0001) begin n_fail++; $display("FAIL split_sh_byte_ena: got %b/%b expected 1000/0001", r_be[0], r_be[1]); end
    n_checks++; if (r_wd[0] !== 32'hEF000000 || r_wd[1] !== 32'h000000BE) begin n_fail++; $display("FAIL split_sh_wr_data: got %h/%h expected ef000000/000000be", r_wd[0], r_wd[1]); end
`else
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL misaligned_lw_error: got err %b data %h expected err 1 data 0", r_err, r_rdata); end
    n_checks++; if (r_req_cycles !== 0) begin n_fail++; $display("FAIL misaligned_lw_no_bus: got %0d bus cycles expected 0", r_req_cycles); end
    n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL misaligned_lw_latency: got %0d expected 1", r_lat); end
    tick;
    do_req(1'b1, 3'b001, 32'h1003, 32'h0000BEEF);
    n_checks++; if (r_err !== 1'b1 || r_req_cycles !== 0) begin n_fail++; $display("FAIL misaligned_sh: got err %b bus cycles %0d expected err 1 cycles 0", r_err, r_req_cycles); end
`endif
    tick;
  endtask

  task automatic test_illegal;
    do_req(1'b1, 3'b011, 32'h1000, 32'h12345678);
    n_checks++; if (r_got !== 1'b1 || r_err !== 1'b1) begin n_fail++; $display("FAIL illegal_store_error: got valid %b err %b expected 1/1", r_got, r_err); end
    n_checks++; if (r_req_cycles !== 0) begin n_fail++; $display("FAIL illegal_store_no_bus: got %0d bus cycles expected 0", r_req_cycles); end
    n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL illegal_store_latency: got %0d expected 1", r_lat); end
    tick;
    do_req(1'b0, 3'b110, 32'h1000, 32'h0);
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL illegal_load: got err %b data %h expected err 1 data 0", r_err, r_rdata); end
    tick;
  endtask

  task automatic test_timeout;
    mem[0] = 32'hCAFEF00D;
    ack_allow = 1'b0;
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    n_checks++; if (r_got !== 1'b1) begin n_fail++; $display("FAIL timeout_response: got %b expected 1", r_got); end
    n_checks++; if (r_req_cycles !== 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 16", r_req_cycles); end
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_error: got err %b data %h expected err 1 data 0", r_err, r_rdata); end
    n_checks++; if (r_lat !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 17", r_lat); end
    tick;
    ack_allow = 1'b1; ack_delay = 15;
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    n_checks++; if (r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL late_ack_rdata: got err %b data %h expected err 0 data cafef00d", r_err, r_rdata); end
    n_checks++; if (r_req_cycles !== 16 || r_lat !== 17) begin n_fail++; $display("FAIL late_ack_timing: got cycles %0d lat %0d expected 16/17", r_req_cycles, r_lat); end
    ack_delay = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    n_checks++; if (r_rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_first_rdata: got %h expected 11111111", r_rdata); end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1004;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_resp: got %b expected 0", req_ready); end
    tick;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_resp: got %b expected 1", req_ready); end
    do_req(1'b0, 3'b010, 32'h1004, 32'h0);
    n_checks++; if (r_rdata !== 32'h22222222 || r_lat !== 2) begin n_fail++; $display("FAIL b2b_second: got data %h lat %0d expected 22222222/2", r_rdata, r_lat); end
    tick;
  endtask

  task automatic test_ena_reset;
    mem[0] = 32'h5A5A5A5A;
    ack_allow = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000;
    tick;
    req_valid = 1'b0;
    tick;
    ena = 1'b0; ack_allow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1000 || bus_byte_ena !== 4'b1111) begin n_fail++; $display("FAIL ena_freeze_bus: got req %b addr %h be %b expected 1 00001000 1111", bus_req, bus_addr, bus_byte_ena); end
      n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL ena_freeze_rsp: got valid %b ready %b expected 0/0", rsp_valid, req_ready); end
    end
    ack_allow = 1'b0; ena = 1'b1;
    tick;
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL ena_resume_bus_req: got %b expected 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_drop: got req %b valid %b expected 0/0", bus_req, rsp_valid); end
    tick;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got valid %b req %b ready %b expected 0 0 1", rsp_valid, bus_req, req_ready); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    test_reset();
    test_load_ext();
    test_store();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_ena_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
